// File: rtl/mux_rr_nto1_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_nto1_if
// Purpose  : Producer/consumer bundle for the N-to-1 round-robin mux.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_rr_nto1_if #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int SELW  = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_nto1.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_nto1
// Purpose  : N-channel registered mux, round-robin or fixed select, with
//            valid/ready handshake on every channel and on the output.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_nto1 #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mux_rr_nto1_if.slave      bus
);

    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_sel;
    logic             r_valid;
    logic [SELW-1:0]  r_ptr;

    logic [N-1:0]     w_grant;
    logic [SELW-1:0]  w_idx;
    logic [WIDTH-1:0] w_data;
    logic             w_hit;
    logic             w_space;
    logic             w_accept;

    // Channel searched k-th when the pointer is p; wraps at N, not 2^SELW.
    function automatic int rr_pos(input logic [SELW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return (s >= N) ? s - N : s;
    endfunction

    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_data  = '0;
        w_hit   = 1'b0;
        if (bus.mode) begin
            // Out-of-range sel values never match any channel index.
            for (int i = 0; i < N; i++) begin
                if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                    w_grant[i] = 1'b1;
                    w_idx      = SELW'(i);
                    w_data     = bus.in_data[i*WIDTH +: WIDTH];
                    w_hit      = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (!w_hit && bus.in_valid[i] && i == rr_pos(r_ptr, k)) begin
                        w_grant[i] = 1'b1;
                        w_idx      = SELW'(i);
                        w_data     = bus.in_data[i*WIDTH +: WIDTH];
                        w_hit      = 1'b1;
                    end
                end
            end
        end
    end

    // Reset also masks the accept path so no producer sees ready while held.
    assign w_space      = (~r_valid | bus.out_ready) & ~rst;
    assign w_accept     = w_hit & w_space;
    assign bus.in_ready = w_grant & {N{w_space}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_data  <= w_data;
                r_sel   <= w_idx;
                r_valid <= 1'b1;
                if (!bus.mode) begin
                    r_ptr <= (w_idx == SELW'(N - 1)) ? '0 : w_idx + 1'b1;
                end
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_data;
    assign bus.out_sel   = r_sel;
    assign bus.out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_nto1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_nto1
// Purpose  : Directed self-checking bench for mux_rr_nto1 (N=4 and N=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_nto1;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mux_rr_nto1_if #(.WIDTH(5), .N(4), .SELW(2)) b4 ();
    mux_rr_nto1_if #(.WIDTH(5), .N(3), .SELW(2)) b3 ();

    mux_rr_nto1 #(.WIDTH(5), .N(4), .SELW(2)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
    );

    mux_rr_nto1 #(.WIDTH(5), .N(3), .SELW(2)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Registered output of the N=4 instance after an edge.
    task automatic chk4(input string tag, input logic v, input logic [1:0] s, input logic [4:0] d);
        check({tag, ".valid"}, 32'(b4.out_valid), 32'(v));
        check({tag, ".sel"},   32'(b4.out_sel),   32'(s));
        check({tag, ".data"},  32'(b4.out_data),  32'(d));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        b4.in_data = {5'h04, 5'h03, 5'h02, 5'h01};
        b4.in_valid = 4'b1111;
        b4.mode = 1'b0;
        b4.sel = 2'd0;
        b4.out_ready = 1'b1;
        b3.in_data = {5'h07, 5'h06, 5'h05};
        b3.in_valid = 3'b000;
        b3.mode = 1'b0;
        b3.sel = 2'd0;
        b3.out_ready = 1'b1;

        // Reset state with requests pending
        step();
        chk4("rst", 1'b0, 2'd0, 5'h00);
        check("rst.in_ready", 32'(b4.in_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("rr0.in_ready", 32'(b4.in_ready), 32'b0001);

        // Round robin over all four channels, back-to-back
        step(); chk4("rr0", 1'b1, 2'd0, 5'h01);
        step(); chk4("rr1", 1'b1, 2'd1, 5'h02);
        step(); chk4("rr2", 1'b1, 2'd2, 5'h03);
        step(); chk4("rr3", 1'b1, 2'd3, 5'h04);
        step(); chk4("rr4", 1'b1, 2'd0, 5'h01);
        // ptr = 1; move it to 2 with a lone request on channel 1
        b4.in_valid = 4'b0010;
        step(); chk4("p2", 1'b1, 2'd1, 5'h02);

        // Sparse requests on 1 and 3 starting from ptr = 2
        b4.in_valid = 4'b1010;
        #1 check("sp0.in_ready", 32'(b4.in_ready), 32'b1000);
        step(); chk4("sp0", 1'b1, 2'd3, 5'h04);
        check("sp1.in_ready", 32'(b4.in_ready), 32'b0010);
        step(); chk4("sp1", 1'b1, 2'd1, 5'h02);
        step(); chk4("sp2", 1'b1, 2'd3, 5'h04);

        // ptr = 0; move it to 1, then fixed select on channel 2
        b4.in_valid = 4'b0001;
        step(); chk4("p1", 1'b1, 2'd0, 5'h01);
        b4.in_valid = 4'b1111;
        b4.mode = 1'b1;
        b4.sel = 2'd2;
        #1 check("fx0.in_ready", 32'(b4.in_ready), 32'b0100);
        step(); chk4("fx0", 1'b1, 2'd2, 5'h03);
        step(); chk4("fx1", 1'b1, 2'd2, 5'h03);
        b4.mode = 1'b0;
        #1 check("ptr_kept.in_ready", 32'(b4.in_ready), 32'b0010);
        step(); chk4("ptr_kept", 1'b1, 2'd1, 5'h02);

        // ptr = 2: load 0x15 from channel 2, then stall the consumer
        b4.in_data = {5'h04, 5'h15, 5'h02, 5'h01};
        b4.in_valid = 4'b0100;
        step(); chk4("bp_load", 1'b1, 2'd2, 5'h15);
        b4.out_ready = 1'b0;
        b4.in_valid = 4'b1111;
        b4.in_data = {5'h14, 5'h13, 5'h12, 5'h11};
        for (int c = 0; c < 3; c++) begin
            #1 check("bp.in_ready", 32'(b4.in_ready), 32'h0);
            step(); chk4("bp_hold", 1'b1, 2'd2, 5'h15);
        end
        b4.out_ready = 1'b1;
        #1 check("bp_rel.in_ready", 32'(b4.in_ready), 32'b1000);
        step(); chk4("bp_rel", 1'b1, 2'd3, 5'h14);

        // Asynchronous reset while a beat is held
        #2 rst = 1'b1;
        #1 chk4("arst", 1'b0, 2'd0, 5'h00);
        check("arst.in_ready", 32'(b4.in_ready), 32'h0);
        step();
        rst = 1'b0;
        #1 check("post_rst.in_ready", 32'(b4.in_ready), 32'b0001);
        step(); chk4("post_rst", 1'b1, 2'd0, 5'h11);

        // N = 3 instance: out-of-range select, then wrap at 3
        b3.in_valid = 3'b111;
        b3.mode = 1'b1;
        b3.sel = 2'd3;
        #1 check("n3_sel3.in_ready", 32'(b3.in_ready), 32'h0);
        step(); check("n3_sel3.valid", 32'(b3.out_valid), 32'h0);
        b3.mode = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("n3_rr.valid", 32'(b3.out_valid), 32'h1);
            check("n3_rr.sel", 32'(b3.out_sel), (c == 3) ? 32'd0 : 32'(c));
        end
        check("n3_rr.data", 32'(b3.out_data), 32'h05);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
